// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and sizing constants for the keypad scanner
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: two-flop synchronizer for idle-high row lines
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    // reset to the idle (all released) level so no phantom press appears
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    assign o_q = r_sync;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan with debounce, release detect and a one-deep key register
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int RELEASE_TICKS = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Scan_tick,
    input  logic [NUM_ROWS-1:0] Row,
    input  logic                Key_ack,
    output logic [NUM_COLS-1:0] Col,
    output logic [3:0]          Key_code,
    output logic                Key_valid,
    output logic                Overrun
);
    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] REL = CNT_W'(RELEASE_TICKS);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [NUM_ROWS-1:0] w_row;
    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt, w_inc;
    logic [1:0]          r_cand, w_cand, r_col, w_col, w_low;
    logic                w_any_low, w_accept;
    logic [3:0]          r_code;
    logic                r_valid, r_ovr;

    row_sync #(.WIDTH(NUM_ROWS)) u_sync (.i_clk(Clock), .i_rst(Reset), .i_d(Row), .o_q(w_row));

    assign w_any_low = ~&w_row;
    assign w_low = !w_row[0] ? 2'd0 : !w_row[1] ? 2'd1 : !w_row[2] ? 2'd2 : 2'd3;
    assign w_inc = r_cnt + ONE;

    // next scan state; every transition is gated by Scan_tick
    always_comb begin
        w_state = r_state;
        w_cnt = r_cnt;
        w_cand = r_cand;
        w_col = r_col;
        w_accept = 1'b0;
        if (Scan_tick)
            case (r_state)
                SCAN:
                    if (!w_any_low) w_col = r_col + 2'd1;
                    else begin
                        w_cand = w_low;
                        w_cnt = ONE;
                        w_accept = (DEB == ONE);
                        w_state = (DEB == ONE) ? PRESSED : DEBOUNCE;
                    end
                DEBOUNCE:
                    if (w_any_low && w_low == r_cand) begin
                        w_cnt = w_inc;
                        w_accept = (w_inc == DEB);
                        w_state = (w_inc == DEB) ? PRESSED : DEBOUNCE;
                    end else begin
                        w_cnt = '0;
                        w_col = r_col + 2'd1;
                        w_state = SCAN;
                    end
                PRESSED:
                    if (!w_any_low) begin
                        w_cnt = (REL == ONE) ? '0 : ONE;
                        w_col = (REL == ONE) ? r_col + 2'd1 : r_col;
                        w_state = (REL == ONE) ? SCAN : RELEASE;
                    end
                RELEASE:
                    if (!w_any_low) begin
                        w_cnt = (w_inc == REL) ? '0 : w_inc;
                        w_col = (w_inc == REL) ? r_col + 2'd1 : r_col;
                        w_state = (w_inc == REL) ? SCAN : RELEASE;
                    end else begin
                        w_cnt = '0;
                        w_state = PRESSED;
                    end
                default: w_state = SCAN;
            endcase
    end

    // scan state, counter, candidate row and active column
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            r_state <= SCAN;
            r_cnt <= '0;
            r_cand <= '0;
            r_col <= '0;
        end else begin
            r_state <= w_state;
            r_cnt <= w_cnt;
            r_cand <= w_cand;
            r_col <= w_col;
        end

    // key holding register: load when empty or being acked, otherwise flag the drop
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            r_code <= '0;
            r_valid <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_ovr <= w_accept && r_valid && !Key_ack;
            if (w_accept && (!r_valid || Key_ack)) begin
                r_code <= {w_cand, r_col};
                r_valid <= 1'b1;
            end else if (Key_ack) r_valid <= 1'b0;
        end

    assign Col = ~(4'b0001 << r_col);
    assign Key_code = r_code;
    assign Key_valid = r_valid;
    assign Overrun = r_ovr;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks of keypad_scanner against a tick-level key model
module tb_keypad_scanner;
    localparam int DEB = 3;
    localparam int REL = 3;
    logic Clock = 0, Reset = 1, Scan_tick = 0, Key_ack = 0;
    logic [3:0] Row = 4'hF;
    logic [3:0] Col, Key_code;
    logic Key_valid, Overrun;
    int errors = 0, checks = 0;
    int m_col, m_held, m_run, m_cand, m_rel, m_valid, m_code, m_accepts;
    bit m_ovr;

    keypad_scanner #(.DEBOUNCE_TICKS(DEB), .RELEASE_TICKS(REL)) dut (
        .Clock(Clock), .Reset(Reset), .Scan_tick(Scan_tick), .Row(Row), .Key_ack(Key_ack),
        .Col(Col), .Key_code(Key_code), .Key_valid(Key_valid), .Overrun(Overrun)
    );

    always #5 Clock = ~Clock;

    function automatic logic [3:0] col_of(int c);
        return ~(4'b0001 << c);
    endfunction

    function automatic int lowest(logic [3:0] r);
        for (int i = 0; i < 4; i++) if (!r[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_col = 0; m_held = 0; m_run = 0; m_cand = 0; m_rel = 0;
        m_valid = 0; m_code = 0; m_ovr = 0;
    endfunction

    // one scan tick seen by a user: count stable samples, emit once per press, wait for release
    function automatic void model_tick(logic [3:0] r, bit ack);
        int low;
        bit acc;
        int code;
        low = lowest(r);
        acc = 0;
        code = 0;
        m_ovr = 0;
        if (!m_held) begin
            if (m_run == 0) begin
                if (low < 0) m_col = (m_col + 1) % 4;
                else begin m_cand = low; m_run = 1; end
            end else if (low == m_cand) m_run++;
            else begin m_run = 0; m_col = (m_col + 1) % 4; end
            if (m_run == DEB) begin
                acc = 1; code = m_cand * 4 + m_col; m_held = 1; m_run = 0; m_rel = 0;
            end
        end else if (low < 0) begin
            m_rel++;
            if (m_rel == REL) begin m_held = 0; m_rel = 0; m_col = (m_col + 1) % 4; end
        end else m_rel = 0;
        if (acc) begin
            m_accepts++;
            if (!m_valid || ack) begin m_valid = 1; m_code = code; end
            else m_ovr = 1;
        end else if (ack) m_valid = 0;
    endfunction

    task automatic tick(input logic [3:0] r, input bit ack);
        @(negedge Clock);
        Scan_tick = 0; Key_ack = 0; Row = r;
        repeat (2) @(negedge Clock);
        Scan_tick = 1; Key_ack = ack;
        model_tick(r, ack);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_ack();
        @(negedge Clock);
        Scan_tick = 0; Key_ack = 1;
        @(posedge Clock);
        #1;
        m_valid = 0;
        @(negedge Clock);
        Key_ack = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", Col); end
        checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Key_valid); end
        checks++; if (Key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %h want 0", Key_code); end
        checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", Overrun); end
        repeat (2) @(negedge Clock);
        Reset = 0;
        model_reset();
    endtask

    task automatic test_idle_rotation();
        for (int i = 0; i < 8; i++) begin
            tick(4'hF, 0);
            checks++; if (Col !== col_of((i + 1) % 4)) begin errors++; $display("FAIL idle_col[%0d]: got %b want %b", i, Col, col_of((i + 1) % 4)); end
            checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b want 0", i, Key_valid); end
        end
    endtask

    task automatic test_press_ack();
        for (int i = 0; i < 4 && m_col != 1; i++) tick(4'hF, 0);
        for (int i = 0; i < 3; i++) tick(4'b1011, 0);
        checks++; if (Key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", Key_valid); end
        checks++; if (Key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", Key_code); end
        @(negedge Clock);
        Scan_tick = 0;
        repeat (6) @(negedge Clock);
        checks++; if (Key_valid !== 1'b1) begin errors++; $display("FAIL press_hold_valid: got %b want 1", Key_valid); end
        do_ack();
        checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL press_ack_clear: got %b want 0", Key_valid); end
        for (int i = 0; i < 3; i++) begin
            tick(4'hF, 0);
            checks++; if (Col !== col_of(m_col)) begin errors++; $display("FAIL press_release_col[%0d]: got %b want %b", i, Col, col_of(m_col)); end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) begin
                tick(j < 2 ? 4'b1110 : 4'b1111, 0);
                checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL bounce_valid[%0d.%0d]: got %b want 0", k, j, Key_valid); end
                checks++; if (Col !== col_of(m_col)) begin errors++; $display("FAIL bounce_col[%0d.%0d]: got %b want %b", k, j, Col, col_of(m_col)); end
            end
    endtask

    task automatic test_overrun();
        logic [3:0] pat;
        logic [3:0] code0;
        pat = ~(4'b0001 << $urandom_range(0, 3));
        for (int i = 0; i < 3; i++) tick(pat, 0);
        code0 = Key_code;
        checks++; if (Key_code !== 4'(m_code) || Key_valid !== 1'b1) begin errors++; $display("FAIL ovr_first: got code %h valid %b want %h 1", Key_code, Key_valid, 4'(m_code)); end
        for (int i = 0; i < 3; i++) tick(4'hF, 0);
        pat = ~(4'b0001 << $urandom_range(0, 3));
        for (int i = 0; i < 3; i++) tick(pat, 0);
        checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", Overrun); end
        checks++; if (Key_code !== code0) begin errors++; $display("FAIL ovr_code_kept: got %h want %h", Key_code, code0); end
        @(negedge Clock);
        Scan_tick = 0;
        @(posedge Clock);
        #1;
        checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b want 0", Overrun); end
        for (int i = 0; i < 3; i++) tick(4'hF, 0);
        pat = ~(4'b0001 << $urandom_range(0, 3));
        for (int i = 0; i < 3; i++) tick(pat, i == 2);
        checks++; if (Key_code !== 4'(m_code) || Key_valid !== 1'b1) begin errors++; $display("FAIL ovr_ack_load: got code %h valid %b want %h 1", Key_code, Key_valid, 4'(m_code)); end
        checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_noovr: got %b want 0", Overrun); end
        for (int i = 0; i < 3; i++) tick(4'hF, 0);
    endtask

    task automatic test_hold_multi();
        int events;
        logic prev;
        do_ack();
        for (int i = 0; i < 4 && m_col != 0; i++) tick(4'hF, 0);
        events = 0;
        prev = Key_valid;
        for (int i = 0; i < 50; i++) begin
            tick(4'b0101, 0);
            if (Key_valid && !prev) events++;
            prev = Key_valid;
        end
        checks++; if (events != 1) begin errors++; $display("FAIL hold_events: got %0d want 1", events); end
        checks++; if (Key_code !== 4'd4) begin errors++; $display("FAIL hold_code: got %0d want 4", Key_code); end
        checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL hold_col: got %b want 1110", Col); end
        for (int i = 0; i < 3; i++) tick(4'hF, 0);
        checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL hold_resume_col: got %b want 1101", Col); end
    endtask

    task automatic test_random();
        logic [3:0] pat;
        int len;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: pat = 4'hF;
                1: pat = 4'($urandom);
                default: pat = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                tick(pat, $urandom_range(0, 3) == 0);
                checks++; if (Col !== col_of(m_col)) begin errors++; $display("FAIL rnd_col[%0d.%0d]: got %b want %b", n, i, Col, col_of(m_col)); end
                checks++; if (Key_valid !== 1'(m_valid)) begin errors++; $display("FAIL rnd_valid[%0d.%0d]: got %b want %0d", n, i, Key_valid, m_valid); end
                checks++; if (Key_code !== 4'(m_code)) begin errors++; $display("FAIL rnd_code[%0d.%0d]: got %h want %h", n, i, Key_code, 4'(m_code)); end
                checks++; if (Overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d.%0d]: got %b want %b", n, i, Overrun, m_ovr); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(4'hF, 0);
        for (int i = 0; i < 2; i++) tick(4'b1101, 0);
        @(negedge Clock);
        Scan_tick = 0;
        #2 Reset = 1;
        #1;
        checks++; if (Col !== 4'b1110 || Key_valid !== 1'b0 || Key_code !== 4'd0 || Overrun !== 1'b0) begin errors++; $display("FAIL rst_debounce: got col %b valid %b code %h ovr %b want 1110 0 0 0", Col, Key_valid, Key_code, Overrun); end
        Row = 4'hF;
        @(negedge Clock);
        Reset = 0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(4'b1101, 0);
        checks++; if (Key_valid !== 1'b1 || Key_code !== 4'd4) begin errors++; $display("FAIL rst_prepress: got valid %b code %0d want 1 4", Key_valid, Key_code); end
        @(negedge Clock);
        Scan_tick = 0;
        #2 Reset = 1;
        #1;
        checks++; if (Col !== 4'b1110 || Key_valid !== 1'b0 || Key_code !== 4'd0 || Overrun !== 1'b0) begin errors++; $display("FAIL rst_valid: got col %b valid %b code %h ovr %b want 1110 0 0 0", Col, Key_valid, Key_code, Overrun); end
        Row = 4'hF;
        @(negedge Clock);
        Reset = 0;
        model_reset();
        tick(4'hF, 0);
        checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL rst_first_scan: got %b want 1101", Col); end
    endtask

    initial begin
        model_reset();
        m_accepts = 0;
        test_reset();
        test_idle_rotation();
        test_press_ack();
        test_bounce();
        test_overrun();
        test_hold_multi();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 3: consecutive Scan_tick samples of a stable press needed to accept a key; legal range 1..15.
REQ-002 SHALL have parameter RELEASE_TICKS, default 3: consecutive Scan_tick samples with all rows high needed to accept a release; legal range 1..15.
REQ-003 SHALL have port Clock  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Scan_tick  input  1  one-Clock-cycle enable pulse from the existing divider; all scan, debounce and release timing counts these pulses.
REQ-006 SHALL have port Row  input  4  keypad row lines, active-low, asynchronous to Clock.
REQ-007 SHALL have port Key_ack  input  1  consumer acknowledge of Key_code.
REQ-008 SHALL have port Col  output  4  column drive, active-low one-hot.
REQ-009 SHALL have port Key_code  output  4  accepted key, row*4+col.
REQ-010 SHALL have port Key_valid  output  1  high while Key_code holds an unacknowledged key.
REQ-011 SHALL have port Overrun  output  1  one-cycle pulse when an accepted key is dropped.

Function
REQ-012 SHALL pass Row through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE; state and counters change only on Scan_tick cycles, except for Key_valid/Overrun handling.
REQ-014 In SCAN, on Scan_tick with all rows high: SHALL rotate Col to the next column (0->1->2->3->0), effective the next cycle.
REQ-015 In SCAN, on Scan_tick with any row low: SHALL hold Col, latch candidate row (lowest-index low row wins), set counter to 1, and go to DEBOUNCE; if DEBOUNCE_TICKS=1, SHALL go directly to PRESSED and accept the key.
REQ-016 In DEBOUNCE, on Scan_tick with the candidate row still the lowest low row: SHALL increment the counter; on reaching DEBOUNCE_TICKS, SHALL accept the key and go to PRESSED.
REQ-017 In DEBOUNCE, on Scan_tick with a different or no row low: SHALL rotate Col and return to SCAN with no output.
REQ-018 Key accept: if Key_valid is low, or Key_ack is high in the same cycle, SHALL load Key_code and set Key_valid the next cycle; otherwise SHALL drop the key, leave Key_code unchanged and pulse Overrun for one cycle.
REQ-019 Key_valid SHALL clear the cycle after Key_ack is sampled high; Key_ack while Key_valid is low SHALL be ignored.
REQ-020 Key_code SHALL stay stable while Key_valid is high.
REQ-021 In PRESSED, on Scan_tick with all rows high: SHALL set counter to 1 and go to RELEASE; other row activity SHALL be ignored.
REQ-022 In RELEASE, on Scan_tick with all rows high: SHALL increment the counter; on reaching RELEASE_TICKS, SHALL rotate Col and go to SCAN. On Scan_tick with any row low, SHALL return to PRESSED.
REQ-023 SHALL emit at most one key per press-release cycle (no auto-repeat).

Reset
REQ-024 Reset SHALL force state SCAN, Col=4'b1110, Key_code=0, Key_valid=0, Overrun=0, counters=0 and synchronizer flops=4'b1111, asynchronously.
REQ-025 Reset asserted mid-debounce or while Key_valid is high SHALL discard the pending key; the first scan after release SHALL start at column 0.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the FSM state enum, NUM_ROWS=4, NUM_COLS=4 and the counter width (4).
REQ-027 SHALL instantiate one sub-module, row_sync (parameterized-width 2-flop synchronizer); the FSM and counters SHALL stay in keypad_scanner.

Verification
REQ-028 Bench SHALL cover: no press, 8 Scan_ticks -> Col sequence 1110,1101,1011,0111,1110,... one step per tick; Key_valid stays 0.
REQ-029 Bench SHALL cover: row 2 held low while col 1 is driven, for 3 ticks -> Key_code=9, Key_valid=1, held until Key_ack, then cleared the next cycle.
REQ-030 Bench SHALL cover: row 0 bounces (low for 2 ticks, high for 1, repeated) -> no Key_valid; Col resumes rotating after each bounce.
REQ-031 Bench SHALL cover: key accepted with Key_valid still high and no ack -> Overrun one-cycle pulse and Key_code unchanged; same case with Key_ack in the accept cycle -> new code loaded, Key_valid stays 1.
REQ-032 Bench SHALL cover: rows 1 and 3 low together on col 0 -> Key_code=4; key held for 50 ticks -> exactly one Key_valid event; release for 3 ticks -> scanning resumes at col 1.
REQ-033 Bench SHALL cover: Reset asserted mid-DEBOUNCE and again while Key_valid=1 -> all outputs at reset values the same cycle; Col=1110.
